// File: rtl/per_target_responder_if.sv
// rtl/per_target_responder_if.sv - request/response bundle between interconnect and target
interface per_target_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                    data_req;
    logic [ADDR_WIDTH-1:0]   data_add;
    logic                    data_wen;
    logic [DATA_WIDTH-1:0]   data_wdata;
    logic [DATA_WIDTH/8-1:0] data_be;
    logic [ID_WIDTH-1:0]     data_id;
    logic                    data_gnt;
    logic                    data_r_valid;
    logic [DATA_WIDTH-1:0]   data_r_rdata;
    logic                    data_r_opc;
    logic [ID_WIDTH-1:0]     data_r_id;

    modport master (
        output data_req, data_add, data_wen, data_wdata, data_be, data_id,
        input  data_gnt, data_r_valid, data_r_rdata, data_r_opc, data_r_id
    );

    modport slave (
        input  data_req, data_add, data_wen, data_wdata, data_be, data_id,
        output data_gnt, data_r_valid, data_r_rdata, data_r_opc, data_r_id
    );
endinterface

// File: rtl/per_target_responder.sv
// rtl/per_target_responder.sv - fixed-latency register-bank target for the peripheral interconnect
module per_target_responder #(
    parameter int                    NUM_REGS     = 8,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ID_WIDTH     = 4,
    parameter int                    RESP_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    per_target_responder_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int LAST  = RESP_LATENCY - 1;

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("per_target_responder: DATA_WIDTH must be 32");
        end
        if (RESP_LATENCY < 1 || RESP_LATENCY > 4) begin : g_bad_latency
            $error("per_target_responder: RESP_LATENCY must be 1..4");
        end
        if (NUM_REGS < 2 || NUM_REGS > 256 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
            $error("per_target_responder: NUM_REGS must be a power of 2 in 2..256");
        end
    endgenerate

    logic                  accept;
    logic                  addr_err;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  pipe_valid [RESP_LATENCY];
    logic [DATA_WIDTH-1:0] pipe_rdata [RESP_LATENCY];
    logic                  pipe_opc   [RESP_LATENCY];
    logic [ID_WIDTH-1:0]   pipe_id    [RESP_LATENCY];
    logic                  out_valid;

    assign accept       = bus.data_req & ~rst;
    assign bus.data_gnt = accept;

    // Any address bit above the index field means the word lies past the bank.
    assign addr_err = (bus.data_add[1:0] != 2'b00) || ((bus.data_add >> (IDX_W + 2)) != '0);
    assign idx      = bus.data_add[IDX_W+1:2];

    always_comb begin
        rsp_rdata = '0;
        if (accept && !addr_err && bus.data_wen) begin
            rsp_rdata = regs[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else if (accept && !addr_err && !bus.data_wen) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.data_be[b]) begin
                    regs[idx][b*8 +: 8] <= bus.data_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Stage 0 captures the whole response; later stages only delay it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RESP_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_rdata[i] <= '0;
                pipe_opc[i]   <= 1'b0;
                pipe_id[i]    <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_rdata[0] <= rsp_rdata;
            pipe_opc[0]   <= accept & addr_err;
            pipe_id[0]    <= accept ? bus.data_id : '0;
            for (int i = 1; i < RESP_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_rdata[i] <= pipe_rdata[i-1];
                pipe_opc[i]   <= pipe_opc[i-1];
                pipe_id[i]    <= pipe_id[i-1];
            end
        end
    end

    // Idle outputs are forced to zero so nothing stale reaches the merge tree.
    assign out_valid        = pipe_valid[LAST] & ~rst;
    assign bus.data_r_valid = out_valid;
    assign bus.data_r_rdata = out_valid ? pipe_rdata[LAST] : '0;
    assign bus.data_r_opc   = out_valid & pipe_opc[LAST];
    assign bus.data_r_id    = out_valid ? pipe_id[LAST] : '0;
endmodule
